// File: rtl/mp64_memory_unit_pkg.sv
// Shared definitions for the mp64 memory subsystem: bus size codes, row geometry,
// CPU-side FSM states and the sizing helpers used for byte-lane merges.
package mp64_memory_unit_pkg;

    localparam int ROW_BITS      = 512;
    localparam int ROW_BYTES     = 64;
    localparam int MEM_BYTES_DEF = 1048576;

    typedef enum logic [1:0] {
        BUS_BYTE  = 2'd0,
        BUS_HALF  = 2'd1,
        BUS_WORD  = 2'd2,
        BUS_DWORD = 2'd3
    } bus_size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_EXT   = 2'd2,
        ST_ACK   = 2'd3
    } cpu_state_e;

    // Offset bits below the access size are dropped, so misaligned addresses round down.
    function automatic logic [2:0] align_off(input logic [2:0] off, input logic [1:0] size);
        logic [2:0] res;
        case (bus_size_e'(size))
            BUS_BYTE: res = off;
            BUS_HALF: res = {off[2:1], 1'b0};
            BUS_WORD: res = {off[2], 2'b00};
            default:  res = 3'b000;
        endcase
        return res;
    endfunction

    function automatic logic [7:0] size_strb(input logic [1:0] size);
        logic [7:0] res;
        case (bus_size_e'(size))
            BUS_BYTE: res = 8'h01;
            BUS_HALF: res = 8'h03;
            BUS_WORD: res = 8'h0F;
            default:  res = 8'hFF;
        endcase
        return res;
    endfunction

    function automatic logic [63:0] size_mask(input logic [1:0] size);
        logic [63:0] res;
        logic [7:0]  strb;
        strb = size_strb(size);
        for (int i = 0; i < 8; i++) res[8*i +: 8] = {8{strb[i]}};
        return res;
    endfunction

endpackage

// File: rtl/mp64_memory_unit_if.sv
// Bus bundle for the memory unit: CPU port, tile port and external forwarding port.
// slave = memory unit side, master = CPU / tile engine / external controller side.
interface mp64_memory_unit_if import mp64_memory_unit_pkg::*; ();

    logic                cpu_req;
    logic [63:0]         cpu_addr;
    logic [63:0]         cpu_wdata;
    logic                cpu_wen;
    logic [1:0]          cpu_size;
    logic [63:0]         cpu_rdata;
    logic                cpu_ack;

    logic                tile_req;
    logic [19:0]         tile_addr;
    logic                tile_wen;
    logic [ROW_BITS-1:0] tile_wdata;
    logic [ROW_BITS-1:0] tile_rdata;
    logic                tile_ack;

    logic                ext_req;
    logic [63:0]         ext_addr;
    logic [63:0]         ext_wdata;
    logic                ext_wen;
    logic [1:0]          ext_size;
    logic [63:0]         ext_rdata;
    logic                ext_ack;

    modport slave (
        input  cpu_req, cpu_addr, cpu_wdata, cpu_wen, cpu_size,
        output cpu_rdata, cpu_ack,
        input  tile_req, tile_addr, tile_wen, tile_wdata,
        output tile_rdata, tile_ack,
        output ext_req, ext_addr, ext_wdata, ext_wen, ext_size,
        input  ext_rdata, ext_ack
    );

    modport master (
        output cpu_req, cpu_addr, cpu_wdata, cpu_wen, cpu_size,
        input  cpu_rdata, cpu_ack,
        output tile_req, tile_addr, tile_wen, tile_wdata,
        input  tile_rdata, tile_ack,
        input  ext_req, ext_addr, ext_wdata, ext_wen, ext_size,
        output ext_rdata, ext_ack
    );

endinterface

// File: rtl/mp64_sram_2p.sv
// Dual-port row RAM (DEPTH x 512) with per-byte write strobes on both ports.
// Reads are combinational; the caller registers the result.
module mp64_sram_2p import mp64_memory_unit_pkg::*; #(
    parameter int DEPTH = 16384,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 a_we,
    input  logic [AW-1:0]        a_addr,
    input  logic [ROW_BYTES-1:0] a_strb,
    input  logic [ROW_BITS-1:0]  a_wdata,
    output logic [ROW_BITS-1:0]  a_rdata,
    input  logic                 b_we,
    input  logic [AW-1:0]        b_addr,
    input  logic [ROW_BYTES-1:0] b_strb,
    input  logic [ROW_BITS-1:0]  b_wdata,
    output logic [ROW_BITS-1:0]  b_rdata
);

    logic [ROW_BITS-1:0] mem [DEPTH];

    // Same-row writes from both ports never coincide: the top serialises them.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ROW_BYTES; i++) begin
            if (a_we && a_strb[i]) mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
            if (b_we && b_strb[i]) mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
        end
    end

    assign a_rdata = mem[a_addr];
    assign b_rdata = mem[b_addr];

endmodule

// File: rtl/mp64_memory_unit.sv
// Mp64 memory unit: sized CPU port + full-row tile port over a dual-port SRAM, with
// CPU accesses >= MEM_BYTES forwarded externally. `define MP64_EXT_TIMEOUT_EN adds an external timeout.
//   state    | meaning
//   ST_IDLE  | ready; internal CPU accesses complete here
//   ST_STALL | CPU deferred one cycle behind a same-row tile access
//   ST_EXT   | external request outstanding, waiting for ext_ack
//   ST_ACK   | cpu_ack pulse for a finished external access
module mp64_memory_unit import mp64_memory_unit_pkg::*; #(
    parameter int unsigned MEM_BYTES   = MEM_BYTES_DEF,
    parameter int          EXT_TIMEOUT = 256
) (
    input  logic               clk,
    input  logic               rst,
    mp64_memory_unit_if.slave  bus
);

    localparam int ROWS = MEM_BYTES / ROW_BYTES;
    localparam int AW   = $clog2(ROWS);

    cpu_state_e          state, state_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic [63:0]         cpu_rdata_q, cpu_rdata_d;
    logic                ext_req_q, ext_req_d;
    logic [63:0]         ext_addr_q, ext_addr_d;
    logic [63:0]         ext_wdata_q, ext_wdata_d;
    logic                ext_wen_q, ext_wen_d;
    logic [1:0]          ext_size_q, ext_size_d;
    logic [AW+5:0]       pend_addr_q, pend_addr_d;
    logic [63:0]         pend_wdata_q, pend_wdata_d;
    logic                pend_wen_q, pend_wen_d;
    logic [1:0]          pend_size_q, pend_size_d;
    logic                tile_ack_q;
    logic [ROW_BITS-1:0] tile_rdata_q;

    logic                cpu_go, tile_go, cpu_int, collide, stalled;
    logic [AW+5:0]       acc_addr;
    logic [63:0]         acc_wdata, acc_mask, rd_val;
    logic                acc_wen;
    logic [1:0]          acc_size;
    logic [AW-1:0]       acc_row, tile_row;
    logic [5:0]          acc_byte;
    logic [ROW_BITS-1:0] row_rd, row_sh, tile_row_rd;
    logic                sram_a_we;
    logic [ROW_BITS-1:0] sram_a_wdata;
    logic [ROW_BYTES-1:0] sram_a_strb;
    logic                unused_ok;

    assign cpu_go   = bus.cpu_req && !cpu_ack_q && (state == ST_IDLE);
    assign tile_go  = bus.tile_req && !tile_ack_q;
    assign cpu_int  = bus.cpu_addr < 64'(MEM_BYTES);
    assign tile_row = bus.tile_addr[AW+5:6];
    assign stalled  = (state == ST_STALL);

    // A deferred CPU access replays from the captured request, not the live bus.
    assign acc_addr  = stalled ? pend_addr_q  : bus.cpu_addr[AW+5:0];
    assign acc_wdata = stalled ? pend_wdata_q : bus.cpu_wdata;
    assign acc_wen   = stalled ? pend_wen_q   : bus.cpu_wen;
    assign acc_size  = stalled ? pend_size_q  : bus.cpu_size;
    assign acc_row   = acc_addr[AW+5:6];
    assign acc_byte  = {acc_addr[5:3], align_off(acc_addr[2:0], acc_size)};
    assign acc_mask  = size_mask(acc_size);
    assign collide   = tile_go && (tile_row == acc_row);

    assign row_sh       = row_rd >> {acc_byte, 3'b000};
    assign rd_val       = row_sh[63:0] & acc_mask;
    assign sram_a_wdata = {448'b0, acc_wdata & acc_mask} << {acc_byte, 3'b000};
    assign sram_a_strb  = {56'b0, size_strb(acc_size)} << acc_byte;

    assign unused_ok = ^bus.tile_addr[5:0];

    mp64_sram_2p #(.DEPTH(ROWS), .AW(AW)) u_sram (
        .clk     (clk),
        .a_we    (sram_a_we),
        .a_addr  (acc_row),
        .a_strb  (sram_a_strb),
        .a_wdata (sram_a_wdata),
        .a_rdata (row_rd),
        .b_we    (tile_go && bus.tile_wen),
        .b_addr  (tile_row),
        .b_strb  ({ROW_BYTES{1'b1}}),
        .b_wdata (bus.tile_wdata),
        .b_rdata (tile_row_rd)
    );

`ifdef MP64_EXT_TIMEOUT_EN
    localparam int CW = $clog2(EXT_TIMEOUT + 1);
    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_cnt_q <= '0;
        else     tmo_cnt_q <= tmo_cnt_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (EXT_TIMEOUT > 0);
`endif

    always_comb begin
        state_d      = state;
        cpu_ack_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        ext_req_d    = ext_req_q;
        ext_addr_d   = ext_addr_q;
        ext_wdata_d  = ext_wdata_q;
        ext_wen_d    = ext_wen_q;
        ext_size_d   = ext_size_q;
        pend_addr_d  = pend_addr_q;
        pend_wdata_d = pend_wdata_q;
        pend_wen_d   = pend_wen_q;
        pend_size_d  = pend_size_q;
        sram_a_we    = 1'b0;
`ifdef MP64_EXT_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif
        unique case (state)
            ST_IDLE: begin
                if (cpu_go) begin
                    if (!cpu_int) begin
                        ext_req_d   = 1'b1;
                        ext_addr_d  = bus.cpu_addr;
                        ext_wdata_d = bus.cpu_wdata;
                        ext_wen_d   = bus.cpu_wen;
                        ext_size_d  = bus.cpu_size;
                        state_d     = ST_EXT;
`ifdef MP64_EXT_TIMEOUT_EN
                        tmo_cnt_d   = CW'(EXT_TIMEOUT - 1);
`endif
                    end else if (collide) begin
                        pend_addr_d  = bus.cpu_addr[AW+5:0];
                        pend_wdata_d = bus.cpu_wdata;
                        pend_wen_d   = bus.cpu_wen;
                        pend_size_d  = bus.cpu_size;
                        state_d      = ST_STALL;
                    end else begin
                        sram_a_we = acc_wen;
                        cpu_ack_d = 1'b1;
                        if (!acc_wen) cpu_rdata_d = rd_val;
                    end
                end
            end
            ST_STALL: begin
                sram_a_we = acc_wen;
                cpu_ack_d = 1'b1;
                if (!acc_wen) cpu_rdata_d = rd_val;
                state_d   = ST_IDLE;
            end
            ST_EXT: begin
                if (bus.ext_ack) begin
                    ext_req_d   = 1'b0;
                    cpu_rdata_d = bus.ext_rdata;
                    cpu_ack_d   = 1'b1;
                    state_d     = ST_ACK;
                end
`ifdef MP64_EXT_TIMEOUT_EN
                else if (tmo_cnt_q == '0) begin
                    ext_req_d   = 1'b0;
                    cpu_rdata_d = '1;
                    cpu_ack_d   = 1'b1;
                    state_d     = ST_ACK;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - 1'b1;
                end
`endif
            end
            ST_ACK: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cpu_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            ext_req_q    <= 1'b0;
            ext_addr_q   <= '0;
            ext_wdata_q  <= '0;
            ext_wen_q    <= 1'b0;
            ext_size_q   <= '0;
            pend_addr_q  <= '0;
            pend_wdata_q <= '0;
            pend_wen_q   <= 1'b0;
            pend_size_q  <= '0;
        end else begin
            state        <= state_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            ext_req_q    <= ext_req_d;
            ext_addr_q   <= ext_addr_d;
            ext_wdata_q  <= ext_wdata_d;
            ext_wen_q    <= ext_wen_d;
            ext_size_q   <= ext_size_d;
            pend_addr_q  <= pend_addr_d;
            pend_wdata_q <= pend_wdata_d;
            pend_wen_q   <= pend_wen_d;
            pend_size_q  <= pend_size_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tile_ack_q   <= 1'b0;
            tile_rdata_q <= '0;
        end else begin
            tile_ack_q <= tile_go;
            if (tile_go && !bus.tile_wen) tile_rdata_q <= tile_row_rd;
        end
    end

    assign bus.cpu_ack    = cpu_ack_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.tile_ack   = tile_ack_q;
    assign bus.tile_rdata = tile_rdata_q;
    assign bus.ext_req    = ext_req_q;
    assign bus.ext_addr   = ext_addr_q;
    assign bus.ext_wdata  = ext_wdata_q;
    assign bus.ext_wen    = ext_wen_q;
    assign bus.ext_size   = ext_size_q;

endmodule

// File: tb/tb_mp64_memory_unit.sv
// Directed bench for mp64_memory_unit: sized CPU access, tile rows, collisions,
// external forwarding and reset mid-access (timeout too when MP64_EXT_TIMEOUT_EN is defined).
module tb_mp64_memory_unit;

    logic clk = 1'b0;
    logic rst;
    int   tests  = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    mp64_memory_unit_if bus();

    mp64_memory_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        assert (act === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cpu_op(input logic [63:0] addr, input logic [63:0] wd, input logic wen,
                          input logic [1:0] sz, output logic [63:0] rd, output int lat);
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_addr = addr; bus.cpu_wdata = wd;
        bus.cpu_wen = wen;  bus.cpu_size = sz;
        lat = 0; rd = '0;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            if (bus.cpu_ack) begin lat = i; rd = bus.cpu_rdata; break; end
        end
        bus.cpu_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic tile_op(input logic [19:0] addr, input logic [511:0] wd, input logic wen,
                           output logic [511:0] rd, output int lat);
        @(negedge clk);
        bus.tile_req = 1'b1; bus.tile_addr = addr; bus.tile_wdata = wd; bus.tile_wen = wen;
        lat = 0; rd = '0;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            if (bus.tile_ack) begin lat = i; rd = bus.tile_rdata; break; end
        end
        bus.tile_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_ext_req(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.ext_req) begin seen = 1'b1; break; end
        end
    endtask

    task automatic ext_reply(input logic [63:0] rd, output logic req_after, output int acks);
        @(negedge clk);
        bus.ext_rdata = rd; bus.ext_ack = 1'b1;
        @(posedge clk); #1;
        req_after = bus.ext_req;
        acks = int'(bus.cpu_ack);
        bus.ext_ack = 1'b0; bus.cpu_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            acks += int'(bus.cpu_ack);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0]  rd;
        logic [511:0] trd, pat0, pat2, exp_row;
        int           lat, acks;
        logic         seen, req_after;

        for (int i = 0; i < 64; i++) begin
            pat0[8*i +: 8] = 8'(i);
            pat2[8*i +: 8] = 8'(8'h80 + i);
        end

        rst = 1'b1;
        bus.cpu_req = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_wen = 0; bus.cpu_size = 0;
        bus.tile_req = 0; bus.tile_addr = '0; bus.tile_wen = 0; bus.tile_wdata = '0;
        bus.ext_rdata = '0; bus.ext_ack = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_cpu_ack",    512'(bus.cpu_ack),    512'(0));
        check("rst_tile_ack",   512'(bus.tile_ack),   512'(0));
        check("rst_ext_req",    512'(bus.ext_req),    512'(0));
        check("rst_cpu_rdata",  512'(bus.cpu_rdata),  512'(0));
        check("rst_tile_rdata", bus.tile_rdata,       512'(0));
        check("rst_ext_addr",   512'(bus.ext_addr),   512'(0));

        // dword round trip and single-cycle latency
        cpu_op(64'h100, 64'hDEADBEEFCAFEBABE, 1'b1, 2'd3, rd, lat);
        check("wr_lat", 512'(lat), 512'(1));
        cpu_op(64'h100, 64'h0, 1'b0, 2'd3, rd, lat);
        check("rd_lat", 512'(lat), 512'(1));
        check("rd_dword_100", 512'(rd), 512'(64'hDEADBEEFCAFEBABE));

        // sized reads and byte-merge write
        cpu_op(64'h200, 64'h0102030405060708, 1'b1, 2'd3, rd, lat);
        cpu_op(64'h200, 64'h0, 1'b0, 2'd0, rd, lat);
        check("rd_byte_200", 512'(rd), 512'(64'h08));
        cpu_op(64'h201, 64'h0, 1'b0, 2'd0, rd, lat);
        check("rd_byte_201", 512'(rd), 512'(64'h07));
        cpu_op(64'h200, 64'h0, 1'b0, 2'd1, rd, lat);
        check("rd_half_200", 512'(rd), 512'(64'h0708));
        cpu_op(64'h200, 64'h0, 1'b0, 2'd2, rd, lat);
        check("rd_word_200", 512'(rd), 512'(64'h05060708));
        cpu_op(64'h203, 64'hAAAAAAAAAAAAAAFF, 1'b1, 2'd0, rd, lat);
        cpu_op(64'h200, 64'h0, 1'b0, 2'd3, rd, lat);
        check("rd_after_bytewr", 512'(rd), 512'(64'h01020304FF060708));
        cpu_op(64'h203, 64'h0, 1'b0, 2'd1, rd, lat);
        check("rd_half_203_aligned", 512'(rd), 512'(64'hFF06));
        cpu_op(64'h206, 64'h0, 1'b0, 2'd2, rd, lat);
        check("rd_word_206_aligned", 512'(rd), 512'(64'h01020304));

        // tile row write/read and cross-port visibility
        tile_op(20'h00000, pat0, 1'b1, trd, lat);
        check("tile_wr_lat", 512'(lat), 512'(1));
        tile_op(20'h00000, '0, 1'b0, trd, lat);
        check("tile_rd_row0", trd, pat0);
        cpu_op(64'h38, 64'h0, 1'b0, 2'd3, rd, lat);
        check("cpu_rd_tile_data", 512'(rd), 512'(64'h3F3E3D3C3B3A3938));
        cpu_op(64'h0, 64'h123456789ABCDEF0, 1'b1, 2'd3, rd, lat);
        exp_row = pat0;
        exp_row[63:0] = 64'h123456789ABCDEF0;
        tile_op(20'h00000, '0, 1'b0, trd, lat);
        check("tile_rd_after_cpu_wr", trd, exp_row);

        // same-row collision: tile first, CPU one cycle later with tile data
        @(negedge clk);
        bus.tile_req = 1'b1; bus.tile_addr = 20'h0013F; bus.tile_wen = 1'b1; bus.tile_wdata = pat2;
        bus.cpu_req = 1'b1; bus.cpu_addr = 64'h100; bus.cpu_wen = 1'b0; bus.cpu_size = 2'd3;
        @(posedge clk); #1;
        check("coll_tile_ack_first", 512'(bus.tile_ack), 512'(1));
        check("coll_cpu_stalled", 512'(bus.cpu_ack), 512'(0));
        bus.tile_req = 1'b0;
        @(posedge clk); #1;
        check("coll_cpu_ack_late", 512'(bus.cpu_ack), 512'(1));
        check("coll_tile_ack_done", 512'(bus.tile_ack), 512'(0));
        check("coll_cpu_rdata", 512'(bus.cpu_rdata), 512'(64'h8786858483828180));
        bus.cpu_req = 1'b0;
        @(posedge clk); #1;

        // different rows: both complete together
        @(negedge clk);
        bus.tile_req = 1'b1; bus.tile_addr = 20'h00000; bus.tile_wen = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_addr = 64'h200; bus.cpu_wen = 1'b0; bus.cpu_size = 2'd3;
        @(posedge clk); #1;
        check("diff_tile_ack", 512'(bus.tile_ack), 512'(1));
        check("diff_cpu_ack", 512'(bus.cpu_ack), 512'(1));
        check("diff_tile_rdata", bus.tile_rdata, exp_row);
        check("diff_cpu_rdata", 512'(bus.cpu_rdata), 512'(64'h01020304FF060708));
        bus.tile_req = 1'b0; bus.cpu_req = 1'b0;
        @(posedge clk); #1;

        // ext_ack while idle is ignored
        @(negedge clk);
        bus.ext_ack = 1'b1;
        @(posedge clk); #1;
        check("stray_ext_ack", 512'(bus.cpu_ack), 512'(0));
        bus.ext_ack = 1'b0;
        @(posedge clk); #1;

        // external read, with tile traffic running during EXT
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_addr = 64'h100000; bus.cpu_wen = 1'b0; bus.cpu_size = 2'd3;
        wait_ext_req(seen);
        check("ext_req_seen", 512'(seen), 512'(1));
        check("ext_addr", 512'(bus.ext_addr), 512'(64'h100000));
        check("ext_size", 512'(bus.ext_size), 512'(3));
        check("ext_wen_rd", 512'(bus.ext_wen), 512'(0));
        tile_op(20'h00100, '0, 1'b0, trd, lat);
        check("tile_during_ext_lat", 512'(lat), 512'(1));
        check("tile_during_ext_data", trd, pat2);
        check("ext_req_held", 512'(bus.ext_req), 512'(1));
        check("ext_no_early_ack", 512'(bus.cpu_ack), 512'(0));
        ext_reply(64'hEEEEFFFF00001111, req_after, acks);
        check("ext_req_dropped", 512'(req_after), 512'(0));
        check("ext_single_ack", 512'(acks), 512'(1));
        check("ext_rdata", 512'(bus.cpu_rdata), 512'(64'hEEEEFFFF00001111));

        // reset in the middle of an external access
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_addr = 64'h200000; bus.cpu_wen = 1'b0; bus.cpu_size = 2'd2;
        wait_ext_req(seen);
        check("ext2_req_seen", 512'(seen), 512'(1));
        @(negedge clk);
        rst = 1'b1; bus.cpu_req = 1'b0;
        #1;
        check("midrst_ext_req", 512'(bus.ext_req), 512'(0));
        check("midrst_cpu_rdata", 512'(bus.cpu_rdata), 512'(0));
        check("midrst_ext_addr", 512'(bus.ext_addr), 512'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            acks += int'(bus.cpu_ack);
        end
        check("midrst_no_ack", 512'(acks), 512'(0));
        cpu_op(64'h100, 64'h0, 1'b0, 2'd3, rd, lat);
        check("sram_kept_over_rst", 512'(rd), 512'(64'h8786858483828180));

        // external byte write forwards its fields
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_addr = 64'h100005; bus.cpu_wdata = 64'h5A;
        bus.cpu_wen = 1'b1; bus.cpu_size = 2'd0;
        wait_ext_req(seen);
        check("extw_addr", 512'(bus.ext_addr), 512'(64'h100005));
        check("extw_wdata", 512'(bus.ext_wdata), 512'(64'h5A));
        check("extw_wen", 512'(bus.ext_wen), 512'(1));
        check("extw_size", 512'(bus.ext_size), 512'(0));
        ext_reply(64'h0, req_after, acks);
        check("extw_single_ack", 512'(acks), 512'(1));

`ifdef MP64_EXT_TIMEOUT_EN
        // unanswered external read aborts after 256 cycles in EXT
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_addr = 64'h300000; bus.cpu_wen = 1'b0; bus.cpu_size = 2'd3;
        lat = 0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk); #1;
            if (bus.cpu_ack) begin lat = i; break; end
        end
        bus.cpu_req = 1'b0;
        check("tmo_cycles_after_accept", 512'(lat - 1), 512'(256));
        check("tmo_rdata", 512'(bus.cpu_rdata), 512'(64'hFFFFFFFFFFFFFFFF));
        check("tmo_ext_req", 512'(bus.ext_req), 512'(0));
        @(negedge clk);
        bus.ext_ack = 1'b1;
        @(posedge clk); #1;
        bus.ext_ack = 1'b0;
        acks = int'(bus.cpu_ack);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            acks += int'(bus.cpu_ack);
        end
        check("tmo_late_ack_ignored", 512'(acks), 512'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mp64_memory_unit.md
Name: mp64_memory_unit

Overview:
- Mp64 on-chip memory subsystem: 1 MiB internal SRAM organised as 16384 rows of 512 bits (64 B), served by two ports.
- CPU port: 64-bit, sized, little-endian. Tile port: full-row 512-bit, for the tile engine.
- CPU addresses at or above 1 MiB are forwarded to an external memory handshake interface.
- Sits between the CPU/tile engine and the external memory controller.

Parameters:
- MEM_BYTES, 1048576: internal SRAM size; must be a multiple of 64; sets the external forwarding boundary.
- EXT_TIMEOUT, 256: cycles before an unanswered external access is aborted (optional feature only).

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU request; held until cpu_ack.
- cpu_addr  in  64  CPU byte address.
- cpu_wdata  in  64  write data, right-aligned (lane 0 = LSB).
- cpu_wen  in  1  1 = write.
- cpu_size  in  2  0 byte, 1 half, 2 word, 3 dword (BUS_BYTE/HALF/WORD/DWORD).
- cpu_rdata  out  64  read data, zero-extended, right-aligned.
- cpu_ack  out  1  one-cycle completion pulse.
- tile_req  in  1  tile request; held until tile_ack.
- tile_addr  in  20  byte address; bits [5:0] ignored (row-aligned).
- tile_wen  in  1  1 = write full row.
- tile_wdata  in  512  row write data; byte n = bits [8n+7:8n].
- tile_rdata  out  512  row read data.
- tile_ack  out  1  one-cycle completion pulse.
- ext_req  out  1  external request; held until ext_ack.
- ext_addr  out  64  forwarded CPU address.
- ext_wdata  out  64  forwarded write data.
- ext_wen  out  1  forwarded write enable.
- ext_size  out  2  forwarded size.
- ext_rdata  in  64  external read data, valid with ext_ack.
- ext_ack  in  1  external completion.

Behaviour:
- Reset: cpu_ack, tile_ack, ext_req, ext_wen = 0; cpu_rdata, tile_rdata, ext_addr, ext_wdata = 0; ext_size = 0; FSM to IDLE. SRAM contents are not reset.
- Handshake, both ports:
  - A request is sampled at a rising edge only when that port's ack is low and the port is not busy.
  - Internal access: registered ack plus data one cycle after acceptance.
  - A port never accepts a request in a cycle where its ack is high, so a req still high during the ack cycle does not start a second access.
  - One outstanding access per port.
- CPU internal access (addr < MEM_BYTES):
  - Row = addr[19:6]; dword lane = addr[5:3]; byte offset = addr[2:0].
  - Offset bits below the size alignment are forced to 0: half ignores bit 0, word ignores bits [1:0], dword ignores [2:0].
  - Writes: byte-enable merge of only the sized bytes; other bytes in the row are unchanged.
  - Reads: selected bytes shifted to bit 0, upper bits 0.
- Tile access:
  - Full-row read or write at tile_addr[19:6].
  - Writes from either port are visible to the other port's next access.
- Collision (both ports accepted in the same cycle, same row): the tile is served first. The CPU stalls exactly one cycle and is then served, seeing the tile's write data. Different rows: both complete in the same cycle.
- External forwarding (CPU addr >= MEM_BYTES), FSM IDLE -> EXT -> ACK -> IDLE:
  - EXT: ext_req = 1; ext_addr, ext_wdata, ext_wen, ext_size are registered copies of the CPU request, held stable.
  - On ext_ack: drop ext_req, latch ext_rdata into cpu_rdata, pulse cpu_ack next cycle.
  - The tile port is unaffected during EXT.
  - An ext_ack outside EXT is ignored.
- Reset asserted mid-operation: the access is abandoned, outputs return to reset values, and no ack is issued.

Optional Feature:
- MP64_EXT_TIMEOUT_EN defined:
  - A counter runs in EXT. After EXT_TIMEOUT cycles without ext_ack, ext_req drops and cpu_ack pulses with cpu_rdata = all ones.
  - A late ext_ack is then ignored.
- Undefined: EXT waits indefinitely for ext_ack.

Decomposition:
- Shared package/defs (mp64_defs.vh): BUS_BYTE=0, BUS_HALF=1, BUS_WORD=2, BUS_DWORD=3; row width 512; MEM_BYTES.
- One natural sub-module, mp64_sram_2p: a 16384x512 dual-port RAM with per-byte write enables (64-bit strobe) on each port.
- Arbitration, sizing and the external FSM stay in the top.

Test Plan:
- CPU dword write 0xDEADBEEFCAFEBABE @0x100, read dword @0x100 -> same value; ack exactly one cycle after acceptance.
- Write dword 0x0102030405060708 @0x200; then:
  - byte @0x200 -> 0x08
  - byte @0x201 -> 0x07
  - half @0x200 -> 0x0708
  - word @0x200 -> 0x05060708
  - byte write 0xFF @0x203, then dword read -> 0x01020304FF060708
- Tile write row 0 with bytes 0x00..0x3F, tile read 0x00000 -> identical 512 bits. CPU dword write 0x123456789ABCDEF0 @0x0, then tile read row 0 -> bits [63:0] = 0x123456789ABCDEF0.
- Same-cycle tile write row 4 and CPU read @0x100 -> tile_ack first; cpu_ack one cycle later with the tile's dword 0. Different rows -> both ack in the same cycle.
- CPU read @0x100000 -> ext_req with ext_addr = 0x100000 and ext_size = 3; respond ext_rdata 0xEEEEFFFF00001111 with a one-cycle ext_ack -> cpu_rdata = 0xEEEEFFFF00001111 and a single cpu_ack.
- With MP64_EXT_TIMEOUT_EN: external read never acked -> cpu_ack after 256 cycles with cpu_rdata = 0xFFFFFFFFFFFFFFFF. Separately, reset asserted mid-EXT -> ext_req = 0 immediately and no cpu_ack.
